ecg_block_rice_encoder: RTL and testbench

// Streaming, parametrised successor to the fixed 8-sample hybrid ECG coder. It accepts ECG samples over a

---
 rtl/ecg_block_rice_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_ecg_block_rice_encoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_block_rice_encoder.sv
// Block-adaptive Golomb-Rice coder for ECG first differences.
// Collects BLK_LEN deltas, picks k from the mean |delta|, then streams HDR/RUN/GR/ESC tokens.
module ecg_block_rice_encoder #(
  parameter int DW      = 16,
  parameter int BLK_LEN = 8,
  parameter int THR_LO  = 100,
  parameter int THR_HI  = 500,
  parameter int K_LO    = 3,
  parameter int K_MID   = 4,
  parameter int K_HI    = 5,
  parameter int Q_W     = 6,
  parameter int RUN_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lossless,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_sample,
  output logic                 tok_valid,
  input  logic                 tok_ready,
  output logic [1:0]           tok_type,
  output logic [DW:0]          tok_data,
  output logic                 busy
);

  localparam int LOG2  = $clog2(BLK_LEN);
  localparam int IDX_W = (LOG2 < 1) ? 1 : LOG2;
  localparam int SUM_W = DW + 1 + LOG2;
  localparam int RUN_W = $clog2(RUN_MAX + 1);

  localparam logic [IDX_W-1:0] LAST     = IDX_W'(BLK_LEN - 1);
  localparam logic [SUM_W-1:0] THR_LO_S = SUM_W'(THR_LO);
  localparam logic [SUM_W-1:0] THR_HI_S = SUM_W'(THR_HI);
  localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(RUN_MAX);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_SELECT,
    S_HDR,
    S_ENCODE,
    S_TAIL
  } state_t;

  typedef enum logic [1:0] {
    TOK_HDR = 2'b00,
    TOK_RUN = 2'b01,
    TOK_GR  = 2'b10,
    TOK_ESC = 2'b11
  } tok_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [SUM_W-1:0]      sum, sum_nxt;
  logic [RUN_W-1:0]      run, run_nxt, run_inc;
  logic [2:0]            k, k_nxt;
  logic signed [DW-1:0]  prev;
  logic                  lossless_q;
  logic signed [DW:0]    dbuf [BLK_LEN];

  logic signed [DW:0]    in_d;
  logic [DW:0]           in_mag;
  logic signed [DW:0]    enc_d;
  logic [DW:0]           enc_mag, enc_q;
  logic [K_HI-1:0]       r_mask, enc_r;
  logic                  enc_run, enc_esc, advance;
  logic [SUM_W-1:0]      mean;
  logic [DW:0]           gr_word;

  // Sign-extend both operands so the difference never overflows.
  assign in_d   = {in_sample[DW-1], in_sample} - {prev[DW-1], prev};
  assign in_mag = in_d[DW] ? -in_d : in_d;

  assign enc_d   = dbuf[idx];
  assign enc_mag = enc_d[DW] ? -enc_d : enc_d;
  assign enc_q   = enc_mag >> k;
  assign r_mask  = (K_HI'(1) << k) - K_HI'(1);
  assign enc_r   = enc_mag[K_HI-1:0] & r_mask;
  assign enc_run = lossless_q ? (enc_d == '0) : (enc_q == '0);
  assign enc_esc = |enc_q[DW:Q_W];
  assign run_inc = run + RUN_W'(1);
  assign mean    = sum >> LOG2;

  always_comb begin
    gr_word                  = '0;
    gr_word[K_HI-1:0]        = enc_r;
    gr_word[K_HI +: Q_W]     = enc_q[Q_W-1:0];
    gr_word[K_HI + Q_W]      = enc_d[DW];
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    sum_nxt   = sum;
    run_nxt   = run;
    k_nxt     = k;
    advance   = 1'b0;
    in_ready  = 1'b0;
    tok_valid = 1'b0;
    tok_type  = TOK_HDR;
    tok_data  = '0;
    busy      = (state != S_COLLECT) || (idx != '0);

    case (state)
      S_COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sum_nxt = sum + SUM_W'(in_mag);
          if (idx == LAST) begin
            idx_nxt   = '0;
            state_nxt = S_SELECT;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end

      S_SELECT: begin
        if (mean < THR_LO_S)      k_nxt = 3'(K_LO);
        else if (mean < THR_HI_S) k_nxt = 3'(K_MID);
        else                      k_nxt = 3'(K_HI);
        sum_nxt   = '0;
        state_nxt = S_HDR;
      end

      S_HDR: begin
        tok_valid = 1'b1;
        tok_type  = TOK_HDR;
        tok_data  = (DW+1)'(k);
        if (tok_ready) begin
          idx_nxt   = '0;
          state_nxt = S_ENCODE;
        end
      end

      S_ENCODE: begin
        if (enc_run) begin
          if (run_inc == RUN_SAT) begin
            tok_valid = 1'b1;
            tok_type  = TOK_RUN;
            tok_data  = (DW+1)'(run_inc);
            if (tok_ready) begin
              run_nxt = '0;
              advance = 1'b1;
            end
          end else begin
            run_nxt = run_inc;
            advance = 1'b1;
          end
        end else if (run != '0) begin
          // Pending run is flushed first; idx stays so this sample is coded next.
          tok_valid = 1'b1;
          tok_type  = TOK_RUN;
          tok_data  = (DW+1)'(run);
          if (tok_ready) run_nxt = '0;
        end else begin
          tok_valid = 1'b1;
          tok_type  = enc_esc ? TOK_ESC : TOK_GR;
          tok_data  = enc_esc ? enc_d : gr_word;
          if (tok_ready) advance = 1'b1;
        end

        if (advance) begin
          if (idx == LAST) begin
            idx_nxt   = '0;
            state_nxt = (run_nxt != '0) ? S_TAIL : S_COLLECT;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end

      S_TAIL: begin
        tok_valid = 1'b1;
        tok_type  = TOK_RUN;
        tok_data  = (DW+1)'(run);
        if (tok_ready) begin
          run_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = S_COLLECT;
        end
      end

      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_COLLECT;
      idx        <= '0;
      sum        <= '0;
      run        <= '0;
      k          <= '0;
      prev       <= '0;
      lossless_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      sum   <= sum_nxt;
      run   <= run_nxt;
      k     <= k_nxt;
      if (state == S_COLLECT && in_valid) begin
        prev <= in_sample;
        if (idx == '0) lossless_q <= lossless;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_COLLECT && in_valid) dbuf[idx] <= in_d;
  end

endmodule

// File: tb/tb_ecg_block_rice_encoder.sv
// Scoreboard bench for ecg_block_rice_encoder: default instance plus a RUN_MAX=3 instance.
module tb_ecg_block_rice_encoder;

  localparam int DW = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          lossless = '0;
  logic [1:0]          in_valid = '0;
  logic [1:0]          in_ready;
  logic [DW-1:0]       in_sample [2];
  logic [1:0]          tok_valid;
  logic [1:0]          tok_ready = '0;
  logic [1:0]          tok_type  [2];
  logic [DW:0]         tok_data  [2];
  logic [1:0]          busy;

  int checks = 0;
  int errors = 0;
  int ready_pct = 100;
  bit stall_gr = 1'b0;

  logic [18:0] exp_q0 [$];
  logic [18:0] exp_q1 [$];
  int          model_prev [2] = '{0, 0};
  bit          held_v [2] = '{1'b0, 1'b0};
  logic [18:0] held_tok [2];

  always #5 clk = ~clk;

  ecg_block_rice_encoder #(
    .DW(DW), .BLK_LEN(8), .THR_LO(100), .THR_HI(500),
    .K_LO(3), .K_MID(4), .K_HI(5), .Q_W(6), .RUN_MAX(255)
  ) u_dut (
    .clk(clk), .rst(rst), .lossless(lossless[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sample(in_sample[0]),
    .tok_valid(tok_valid[0]), .tok_ready(tok_ready[0]),
    .tok_type(tok_type[0]), .tok_data(tok_data[0]), .busy(busy[0])
  );

  ecg_block_rice_encoder #(
    .DW(DW), .BLK_LEN(8), .THR_LO(100), .THR_HI(500),
    .K_LO(3), .K_MID(4), .K_HI(5), .Q_W(6), .RUN_MAX(3)
  ) u_dut_rm3 (
    .clk(clk), .rst(rst), .lossless(lossless[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sample(in_sample[1]),
    .tok_valid(tok_valid[1]), .tok_ready(tok_ready[1]),
    .tok_type(tok_type[1]), .tok_data(tok_data[1]), .busy(busy[1])
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_tok(input int sel, input int t, input int v);
    logic [18:0] e;
    e = {2'(t), 17'(v)};
    if (sel == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
  endtask

  function automatic int q_size(input int sel);
    return (sel == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Independent reference: per-block k choice and token sequence.
  task automatic model_block(input int sel, input int samp[8], input bit ls);
    int d [8];
    int p, sum, mean, k, run, rmax, mag, q, r;
    p = model_prev[sel];
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      d[i] = samp[i] - p;
      p = samp[i];
      sum += (d[i] < 0) ? -d[i] : d[i];
    end
    model_prev[sel] = p;
    mean = sum / 8;
    if (mean < 100)      k = 3;
    else if (mean < 500) k = 4;
    else                 k = 5;
    push_tok(sel, 0, k);
    rmax = (sel == 0) ? 255 : 3;
    run = 0;
    for (int i = 0; i < 8; i++) begin
      mag = (d[i] < 0) ? -d[i] : d[i];
      q = mag >> k;
      r = mag % (1 << k);
      if (ls ? (d[i] == 0) : (q == 0)) begin
        run++;
        if (run == rmax) begin
          push_tok(sel, 1, run);
          run = 0;
        end
      end else begin
        if (run > 0) begin
          push_tok(sel, 1, run);
          run = 0;
        end
        if (q < 64) push_tok(sel, 2, ((d[i] < 0) ? 2048 : 0) + q * 32 + r);
        else        push_tok(sel, 3, d[i]);
      end
    end
    if (run > 0) push_tok(sel, 1, run);
  endtask

  task automatic mon_step(input int sel);
    logic        v, rdy;
    logic [1:0]  t;
    logic [16:0] dt;
    logic [18:0] e;
    if (rst) begin
      held_v[sel] = 1'b0;
      tok_ready[sel] = 1'b0;
    end else begin
      v  = tok_valid[sel];
      t  = tok_type[sel];
      dt = tok_data[sel];
      if (held_v[sel]) begin
        chk_val("stall_valid", 32'(v), 32'd1);
        chk_val("stall_payload", 32'({t, dt}), 32'(held_tok[sel]));
      end
      if (v) chk_val("ready_outside_collect", 32'(in_ready[sel]), 32'd0);
      rdy = (stall_gr && t == 2'b10) ? 1'b0 : ($urandom_range(99) < ready_pct);
      tok_ready[sel] = rdy;
      if (v && rdy) begin
        if (q_size(sel) == 0) begin
          chk_val("unexpected_token", 32'({t, dt}), 32'h7FFFF);
        end else begin
          e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk_val("tok_type", 32'(t), 32'(e[18:17]));
          chk_val("tok_data", 32'(dt), 32'(e[16:0]));
        end
        held_v[sel] = 1'b0;
      end else begin
        held_v[sel] = v;
      end
      held_tok[sel] = {t, dt};
    end
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic drive_block(input int sel, input int samp[8], input bit ls, input bit gaps);
    int n;
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(99) < 30) begin
        @(negedge clk);
        in_valid[sel] = 1'b0;
      end
      n = 0;
      do begin
        @(negedge clk);
        in_valid[sel]  = 1'b1;
        in_sample[sel] = 16'(samp[i]);
        lossless[sel]  = (i == 0 || !gaps) ? ls : 1'($urandom_range(1));
        n++;
      end while (!in_ready[sel] && n < 4000);
      if (!in_ready[sel]) chk_val("in_ready_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    in_valid[sel] = 1'b0;
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while ((q_size(sel) != 0 || busy[sel]) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk_val("drain_done", 32'((q_size(sel) == 0) && !busy[sel]), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    @(negedge clk);
    exp_q0.delete();
    exp_q1.delete();
    model_prev = '{0, 0};
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_test1(input int sel);
    push_tok(sel, 0, 4);
    push_tok(sel, 2, 12'h7C8);
    push_tok(sel, 1, 7);
  endtask

  initial begin
    int blk [8];
    int n, p, s;
    in_sample[0] = '0;
    in_sample[1] = '0;

    do_reset();
    for (int sel = 0; sel < 2; sel++) begin
      chk_val("rst_in_ready", 32'(in_ready[sel]), 32'd1);
      chk_val("rst_tok_valid", 32'(tok_valid[sel]), 32'd0);
      chk_val("rst_tok_type", 32'(tok_type[sel]), 32'd0);
      chk_val("rst_tok_data", 32'(tok_data[sel]), 32'd0);
      chk_val("rst_busy", 32'(busy[sel]), 32'd0);
    end

    // Constant 1000: one GR then a tail run.
    blk = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    push_test1(0);
    drive_block(0, blk, 1'b0, 1'b0);
    drain(0);

    // Large step escapes.
    do_reset();
    blk = '{20000, 20000, 20000, 20000, 20000, 20000, 20000, 20000};
    push_tok(0, 0, 5);
    push_tok(0, 3, 20000);
    push_tok(0, 1, 7);
    drive_block(0, blk, 1'b0, 1'b0);
    drain(0);

    // Lossy vs lossless run definition.
    do_reset();
    blk = '{0, 5, 5, 5, 5, 5, 5, 5};
    push_tok(0, 0, 3);
    push_tok(0, 1, 8);
    drive_block(0, blk, 1'b0, 1'b0);
    drain(0);
    do_reset();
    push_tok(0, 0, 3);
    push_tok(0, 1, 1);
    push_tok(0, 2, 5);
    push_tok(0, 1, 6);
    drive_block(0, blk, 1'b1, 1'b0);
    drain(0);

    // RUN_MAX=3 saturation, prev carried into the second block.
    do_reset();
    blk = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    push_tok(1, 0, 4);
    push_tok(1, 2, 12'h7C8);
    push_tok(1, 1, 3);
    push_tok(1, 1, 3);
    push_tok(1, 1, 1);
    push_tok(1, 0, 3);
    push_tok(1, 1, 3);
    push_tok(1, 1, 3);
    push_tok(1, 1, 2);
    drive_block(1, blk, 1'b0, 1'b0);
    drive_block(1, blk, 1'b0, 1'b0);
    drain(1);

    // Reset while the GR token is stalled, then replay.
    do_reset();
    stall_gr = 1'b1;
    push_test1(0);
    drive_block(0, blk, 1'b0, 1'b0);
    n = 0;
    while (!(tok_valid[0] && tok_type[0] == 2'b10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_val("gr_stall_seen", 32'(tok_valid[0] && tok_type[0] == 2'b10), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_val("midrst_tok_valid", 32'(tok_valid[0]), 32'd0);
    chk_val("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    chk_val("midrst_busy", 32'(busy[0]), 32'd0);
    exp_q0.delete();
    model_prev = '{0, 0};
    stall_gr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_test1(0);
    drive_block(0, blk, 1'b0, 1'b0);
    drain(0);

    // Random blocks with stalls and input gaps on both instances.
    do_reset();
    ready_pct = 30;
    for (int sel = 0; sel < 2; sel++) begin
      p = 0;
      for (int b = 0; b < ((sel == 0) ? 1000 : 200); b++) begin
        for (int i = 0; i < 8; i++) begin
          case ($urandom_range(4))
            0: s = p;
            1: s = p + int'($urandom_range(16)) - 8;
            2: s = p + int'($urandom_range(600)) - 300;
            3: s = p + int'($urandom_range(4000)) - 2000;
            default: s = int'($urandom_range(65535)) - 32768;
          endcase
          if (s > 32767)  s = 32767;
          if (s < -32768) s = -32768;
          blk[i] = s;
          p = s;
        end
        s = int'($urandom_range(1));
        model_block(sel, blk, s[0]);
        drive_block(sel, blk, s[0], 1'b1);
      end
      drain(sel);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
